// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scanner: hex glyphs, blank code, index width helper.
package sevenseg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // abcdefg, active-low, indexed by nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_hex_lut.sv
// Combinational nibble to abcdefg (active-low) segment decoder.
module seg7_hex_lut
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_abcdefg
);

    always_comb begin
        seg_abcdefg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous update buffering,
// per-digit blank/dp, leading-zero suppression and PWM dimming; outputs registered.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int CLK_DIV  = 5000,
    parameter int PWM_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   dig,
    input  logic                  dig_valid,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lz_en,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            SEG,
    output logic                  frame_start
);

    localparam int IW = idx_width(DIGITS);
    localparam int CW = idx_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;

    logic [4*DIGITS-1:0]   pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
    logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                  pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
    logic                  pend_vld_q, pend_vld_d;

    logic                  wrap_q, wrap_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  fs_q, fs_d;

    logic                  slot_tick;
    logic                  boundary;
    logic [DIGITS-1:0]     lz_sup;
    logic                  lz_run;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_glyph;
    logic                  visible;
    logic                  pwm_on;

    seg7_hex_lut u_lut (
        .nibble      (cur_nibble),
        .seg_abcdefg (cur_glyph)
    );

    always_comb begin
        slot_tick = (cnt_q == CNT_MAX);
        boundary  = slot_tick && (idx_q == IDX_MAX);

        cnt_d = slot_tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        pwm_d = pwm_q + 1'b1;

        // Boundary takes the old pending set; a coincident strobe refills pending.
        act_dig_d    = act_dig_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        act_lz_d     = act_lz_q;
        pend_dig_d   = pend_dig_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        pend_lz_d    = pend_lz_q;
        pend_vld_d   = pend_vld_q;
        if (boundary && pend_vld_q) begin
            act_dig_d   = pend_dig_q;
            act_blank_d = pend_blank_q;
            act_dp_d    = pend_dp_q;
            act_lz_d    = pend_lz_q;
            pend_vld_d  = 1'b0;
        end
        if (dig_valid) begin
            pend_dig_d   = dig;
            pend_blank_d = blank_mask;
            pend_dp_d    = dp_mask;
            pend_lz_d    = lz_en;
            pend_vld_d   = 1'b1;
        end

        // Zeros from the top digit down stay dark until the first nonzero nibble.
        lz_sup = '0;
        lz_run = act_lz_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run    = lz_run & (act_dig_q[4*i +: 4] == 4'h0);
            lz_sup[i] = lz_run;
        end

        cur_nibble = act_dig_q[{idx_q, 2'b00} +: 4];
        visible    = ~act_blank_q[idx_q] & ~lz_sup[idx_q];
        pwm_on     = (pwm_q <= brightness);

        an_d  = '1;
        seg_d = SEG_BLANK;
        if (visible && pwm_on) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = {cur_glyph, ~act_dp_q[idx_q]};
        end

        wrap_d = boundary;
        fs_d   = wrap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            pend_dig_q   <= '0;
            pend_blank_q <= '1;
            pend_dp_q    <= '0;
            pend_lz_q    <= 1'b0;
            pend_vld_q   <= 1'b0;
            act_dig_q    <= '0;
            act_blank_q  <= '1;
            act_dp_q     <= '0;
            act_lz_q     <= 1'b0;
            wrap_q       <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            pend_dig_q   <= pend_dig_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            pend_lz_q    <= pend_lz_d;
            pend_vld_q   <= pend_vld_d;
            act_dig_q    <= act_dig_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            act_lz_q     <= act_lz_d;
            wrap_q       <= wrap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            fs_q         <= fs_d;
        end
    end

    assign AN          = an_q;
    assign SEG         = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: directed scenarios plus random updates against a time-indexed display model.
module tb_sevenseg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int CLK_DIV  = 4;
    localparam int PWM_BITS = 2;
    localparam int FRAME    = DIGITS * CLK_DIV;
    localparam int PWM_MOD  = 1 << PWM_BITS;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dig = '0;
    logic        dig_valid = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic        lz_en = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  AN;
    logic [7:0]  SEG;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    sevenseg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .CLK_DIV  (CLK_DIV),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dig         (dig),
        .dig_valid   (dig_valid),
        .blank_mask  (blank_mask),
        .dp_mask     (dp_mask),
        .lz_en       (lz_en),
        .brightness  (brightness),
        .AN          (AN),
        .SEG         (SEG),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Model: m_t = clocks since reset release; pending/active data sets as plain variables.
    int          m_t = 0;
    logic [15:0] m_pdig = '0, m_adig = '0;
    logic [3:0]  m_pblank = 4'hF, m_ablank = 4'hF;
    logic [3:0]  m_pdp = '0, m_adp = '0;
    logic        m_plz = 1'b0, m_alz = 1'b0, m_pv = 1'b0;
    logic [3:0]  exp_an = 4'hF;
    logic [7:0]  exp_seg = 8'hFF;
    logic        exp_fs = 1'b0;

    function automatic logic [12:0] model_out(input int t);
        int   idx;
        int   pwm;
        int   hi;
        logic vis;
        logic [3:0] nib;
        logic [3:0] an;
        logic [7:0] seg;
        logic fs;
        idx = (t / CLK_DIV) % DIGITS;
        pwm = t % PWM_MOD;
        hi  = -1;
        for (int i = 0; i < DIGITS; i++)
            if (m_adig[4*i +: 4] != 4'h0) hi = i;
        nib = m_adig[4*idx +: 4];
        vis = !m_ablank[idx] && !(m_alz && idx != 0 && idx > hi);
        an  = 4'hF;
        seg = 8'hFF;
        if (vis && pwm <= int'(brightness)) begin
            an  = ~(4'b0001 << idx);
            seg = {GLYPH[nib], ~m_adp[idx]};
        end
        fs = (t > 0) && (t % FRAME == 0);
        return {fs, an, seg};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t      <= 0;
            m_pdig   <= '0;
            m_adig   <= '0;
            m_pblank <= 4'hF;
            m_ablank <= 4'hF;
            m_pdp    <= '0;
            m_adp    <= '0;
            m_plz    <= 1'b0;
            m_alz    <= 1'b0;
            m_pv     <= 1'b0;
            exp_an   <= 4'hF;
            exp_seg  <= 8'hFF;
            exp_fs   <= 1'b0;
        end else begin
            {exp_fs, exp_an, exp_seg} <= model_out(m_t);
            if ((m_t % FRAME == FRAME - 1) && m_pv) begin
                m_adig   <= m_pdig;
                m_ablank <= m_pblank;
                m_adp    <= m_pdp;
                m_alz    <= m_plz;
                m_pv     <= 1'b0;
            end
            if (dig_valid) begin
                m_pdig   <= dig;
                m_pblank <= blank_mask;
                m_pdp    <= dp_mask;
                m_plz    <= lz_en;
                m_pv     <= 1'b1;
            end
            m_t <= m_t + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        assert (AN === exp_an) else begin
            errors++;
            $error("FAIL an t=%0d observed=%b expected=%b", m_t, AN, exp_an);
        end
        checks++;
        assert (SEG === exp_seg) else begin
            errors++;
            $error("FAIL seg t=%0d observed=%h expected=%h", m_t, SEG, exp_seg);
        end
        checks++;
        assert (frame_start === exp_fs) else begin
            errors++;
            $error("FAIL frame_start t=%0d observed=%b expected=%b", m_t, frame_start, exp_fs);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [15:0] d, input logic [3:0] b,
                          input logic [3:0] p, input logic l);
        dig        = d;
        blank_mask = b;
        dp_mask    = p;
        lz_en      = l;
        dig_valid  = 1'b1;
        tick();
        dig_valid  = 1'b0;
    endtask

    task automatic duty_check(input string tag, input int want);
        int lit;
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (AN != 4'hF) lit++;
        end
        checks++;
        assert (lit === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, lit, want);
        end
    endtask

    initial begin
        logic [15:0] msk;

        run(3);
        rst = 1'b0;
        run(20);

        // Plain hex scan
        brightness = 2'd3;
        strobe(16'h12AF, 4'b0000, 4'b0000, 1'b0);
        run(3 * FRAME);

        // Leading-zero suppression with a dp on a suppressed digit
        strobe(16'h0050, 4'b0000, 4'b1000, 1'b1);
        run(2 * FRAME);

        // PWM duty with only digit 0 visible
        strobe(16'h0007, 4'b1110, 4'b0000, 1'b0);
        run(2 * FRAME);
        brightness = 2'd1;
        run(FRAME);
        duty_check("duty_b1", 2);
        brightness = 2'd0;
        run(FRAME);
        duty_check("duty_b0", 1);
        brightness = 2'd3;
        duty_check("duty_b3", 4);

        // Two strobes inside one frame: last one wins at the boundary
        while (m_t % FRAME != 5) tick();
        strobe(16'h1111, 4'b0000, 4'b0000, 1'b0);
        run(3);
        strobe(16'h2222, 4'b0000, 4'b0000, 1'b0);
        run(3 * FRAME);

        // Strobe coincident with the boundary cycle
        strobe(16'h9876, 4'b0000, 4'b0101, 1'b0);
        while (m_t % FRAME != FRAME - 1) tick();
        strobe(16'hC3D4, 4'b0010, 4'b0000, 1'b0);
        run(3 * FRAME);

        // Random updates with live brightness changes
        for (int k = 0; k < 40; k++) begin
            run($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) brightness = 2'($urandom);
            case ($urandom_range(0, 4))
                0: msk = 16'hFFFF;
                1: msk = 16'h0FFF;
                2: msk = 16'h00FF;
                3: msk = 16'h000F;
                default: msk = 16'h0000;
            endcase
            strobe(16'($urandom) & msk, 4'($urandom) & 4'($urandom),
                   4'($urandom), 1'($urandom));
        end
        run(2 * FRAME);

        // Asynchronous reset mid-slot
        brightness = 2'd3;
        strobe(16'h8888, 4'b0000, 4'b1111, 1'b0);
        run(2 * FRAME + 2);
        #3 rst = 1'b1;
        #1;
        checks++;
        assert (AN === 4'hF) else begin
            errors++;
            $error("FAIL async_rst_an observed=%b expected=%b", AN, 4'hF);
        end
        checks++;
        assert (SEG === 8'hFF) else begin
            errors++;
            $error("FAIL async_rst_seg observed=%h expected=%h", SEG, 8'hFF);
        end
        checks++;
        assert (frame_start === 1'b0) else begin
            errors++;
            $error("FAIL async_rst_fs observed=%b expected=%b", frame_start, 1'b0);
        end
        #2 rst = 1'b0;
        run(3 * FRAME);
        strobe(16'h4321, 4'b0000, 4'b0000, 1'b0);
        run(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
